code_loader: RTL

//  Parametrised successor to the 4-slot master-code loader. Holds the secret code as NUM_SLOTS symbols of SYM_W bits; 0 = empty slot.

---
 rtl/mm_pkg.sv | 32 +++
 rtl/code_loader_lfsr16.sv | 35 +++
 rtl/code_loader.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/mm_pkg.sv
// Shared types and constants for the master-code loader.
//   SYM_W_DEFAULT / MAX_SYM_DEFAULT : default symbol width and largest legal symbol
//   sym_t                           : one code symbol at the default width
//   fill_state_t                    : random-fill sequencer states
//   LFSR_MASK                       : Galois feedback mask of the 16-bit LFSR
package mm_pkg;

  localparam int SYM_W_DEFAULT   = 3;
  localparam int MAX_SYM_DEFAULT = 6;

  typedef logic [SYM_W_DEFAULT-1:0] sym_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  // One step of a right-shifting Galois LFSR.
  function automatic logic [15:0] lfsr_step(input logic [15:0] cur, input logic [15:0] mask);
    logic [15:0] nxt;
    nxt = {1'b0, cur[15:1]};
    if (cur[0]) begin
      nxt = nxt ^ mask;
    end else begin
      nxt = nxt;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/code_loader_lfsr16.sv
// Free-running 16-bit Galois LFSR used as the random symbol source.
//   CLOCK_50 : clock, rising edge
//   reset    : asynchronous active-high, loads SEED
//   state    : current LFSR value (steps every cycle)
module lfsr16
  import mm_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1,
  parameter logic [15:0] MASK = 16'hB400
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  output logic [15:0] state
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  // Next LFSR value; the register is never gated.
  always_comb begin
    state_d = lfsr_step(state_q, MASK);
  end

  // LFSR state register.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/code_loader.sv
// Master-code loader: holds NUM_SLOTS symbols (0 = empty), supports manual
// load / overwrite / single-slot clear with range checking, and a random fill
// of the empty slots from an LFSR.
//   CLOCK_50, reset         : clock and asynchronous active-high reset
//   clear_all               : synchronous clear of all slots, aborts a fill
//   game_playing            : code locked; loads and fills refused
//   load_req/slot/sym       : manual load strobe, target slot, symbol
//   overwrite               : allow replacing a full slot; with sym 0 clears it
//   fill_req                : start a random fill of the empty slots
//   code                    : flattened slots, slot i at [i*SYM_W +: SYM_W]
//   slot_full / all_loaded  : per-slot non-empty flags and their AND
//   busy                    : fill in progress
//   load_err / fill_done    : single-cycle status pulses
module code_loader
  import mm_pkg::*;
#(
  parameter int          NUM_SLOTS = 4,
  parameter int          SYM_W     = SYM_W_DEFAULT,
  parameter int          MAX_SYM   = MAX_SYM_DEFAULT,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int         SLOT_W    = $clog2(NUM_SLOTS)
) (
  input  logic                       CLOCK_50,
  input  logic                       reset,
  input  logic                       clear_all,
  input  logic                       game_playing,
  input  logic                       load_req,
  input  logic [SLOT_W-1:0]          load_slot,
  input  logic [SYM_W-1:0]           load_sym,
  input  logic                       overwrite,
  input  logic                       fill_req,
  output logic [NUM_SLOTS*SYM_W-1:0] code,
  output logic [NUM_SLOTS-1:0]       slot_full,
  output logic                       all_loaded,
  output logic                       busy,
  output logic                       load_err,
  output logic                       fill_done
);

  if (LFSR_SEED == 16'h0000) begin : g_bad_seed
    $error("code_loader: LFSR_SEED must be nonzero");
  end
  if (NUM_SLOTS < 2) begin : g_bad_slots
    $error("code_loader: NUM_SLOTS must be at least 2");
  end
  if (MAX_SYM > (2**SYM_W) - 1 || MAX_SYM < 1) begin : g_bad_max
    $error("code_loader: MAX_SYM must lie in 1..2**SYM_W-1");
  end

  localparam logic [SLOT_W-1:0] LAST_IDX = SLOT_W'(NUM_SLOTS - 1);

  typedef logic [SYM_W-1:0] slot_sym_t;

  slot_sym_t   slot_q [NUM_SLOTS];
  slot_sym_t   slot_d [NUM_SLOTS];
  fill_state_t state_q, state_d;
  logic [SLOT_W-1:0] idx_q, idx_d;
  logic        load_err_q, load_err_d;
  logic        fill_done_q, fill_done_d;

  logic [15:0] lfsr_state;
  logic        lfsr_unused;
  slot_sym_t   cand;
  logic        cand_legal;
  logic        slot_ok;
  logic        sym_legal;
  logic        target_full;
  logic        load_accept;
  logic        advance;

  lfsr16 #(
    .SEED (LFSR_SEED),
    .MASK (LFSR_MASK)
  ) u_lfsr (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .state    (lfsr_state)
  );

  assign cand        = lfsr_state[SYM_W-1:0];
  assign lfsr_unused = ^lfsr_state[15:SYM_W];

  // Manual-load acceptance decode and candidate legality.
  always_comb begin
    cand_legal  = (cand != {SYM_W{1'b0}}) && (cand <= SYM_W'(MAX_SYM));
    // Widened compare so a non-power-of-two slot count is range checked.
    slot_ok     = ({1'b0, load_slot} < (SLOT_W + 1)'(NUM_SLOTS));
    sym_legal   = (load_sym != {SYM_W{1'b0}}) && (load_sym <= SYM_W'(MAX_SYM));
    if (slot_ok) begin
      target_full = (slot_q[load_slot] != {SYM_W{1'b0}});
    end else begin
      target_full = 1'b0;
    end
    load_accept = load_req && !game_playing && (state_q == IDLE) && slot_ok &&
                  ((sym_legal && (!target_full || overwrite)) ||
                   ((load_sym == {SYM_W{1'b0}}) && overwrite));
  end

  // Next-state logic: clear_all beats the fill sequencer, which beats manual loads.
  always_comb begin
    slot_d      = slot_q;
    state_d     = state_q;
    idx_d       = idx_q;
    fill_done_d = 1'b0;
    advance     = 1'b0;
    load_err_d  = load_req && !load_accept;

    if (clear_all) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_d[i] = {SYM_W{1'b0}};
      end
      state_d = IDLE;
      idx_d   = {SLOT_W{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (load_accept) begin
            slot_d[load_slot] = load_sym;
          end else begin
            slot_d = slot_q;
          end
          if (fill_req && !game_playing) begin
            state_d = FILL;
            idx_d   = {SLOT_W{1'b0}};
          end else begin
            state_d = IDLE;
          end
        end
        FILL: begin
          if (game_playing) begin
            // Lock-out aborts the fill; slots written so far stay.
            state_d = IDLE;
            idx_d   = {SLOT_W{1'b0}};
          end else begin
            if (slot_q[idx_q] != {SYM_W{1'b0}}) begin
              advance = 1'b1;
            end else if (cand_legal) begin
              slot_d[idx_q] = cand;
              advance       = 1'b1;
            end else begin
              advance = 1'b0;
            end
            if (advance && (idx_q == LAST_IDX)) begin
              state_d     = IDLE;
              idx_d       = {SLOT_W{1'b0}};
              fill_done_d = 1'b1;
            end else if (advance) begin
              idx_d = idx_q + SLOT_W'(1);
            end else begin
              idx_d = idx_q;
            end
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = {SLOT_W{1'b0}};
        end
      endcase
    end
  end

  // State, slot and status-pulse registers.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_q[i] <= {SYM_W{1'b0}};
      end
      state_q     <= IDLE;
      idx_q       <= {SLOT_W{1'b0}};
      load_err_q  <= 1'b0;
      fill_done_q <= 1'b0;
    end else begin
      slot_q      <= slot_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      load_err_q  <= load_err_d;
      fill_done_q <= fill_done_d;
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_code
    assign code[g*SYM_W +: SYM_W] = slot_q[g];
    assign slot_full[g]           = (slot_q[g] != {SYM_W{1'b0}});
  end

  assign all_loaded = &slot_full;
  assign busy       = (state_q == FILL);
  assign load_err   = load_err_q;
  assign fill_done  = fill_done_q;

endmodule
